irq_ctrl: RTL

Parametrised interrupt controller for the chad MCU. It replaces the fixed 3-source pending register and bare priority encoder with N maskable channels. Each channel has per-channel edge or level mode, software set, and write-1-to-clear. It sits between peripheral IRQ strobes and the CPU irq/ivec/iack pins, and exposes 4 I/O registers on the CPU I/O bus.

---
 rtl/irq_pkg.sv | 12 +
 rtl/irq_ctrl_prio.sv | 23 ++
 rtl/irq_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared constants for the irq_ctrl interrupt controller: I/O register
// addresses and the "no interrupt" vector.
package irq_pkg;

  localparam logic [1:0] IRQ_PEND  = 2'd0;
  localparam logic [1:0] IRQ_ENAB  = 2'd1;
  localparam logic [1:0] IRQ_MODE  = 2'd2;
  localparam logic [1:0] IRQ_SWSET = 2'd3;

  localparam int unsigned IRQ_NONE = 0;

endpackage

// File: rtl/irq_ctrl_prio.sv
// Combinational highest-set-bit encoder: returns channel number (bit index + 1)
// of the highest requesting channel, or IRQ_NONE when nothing is requesting.
module irq_prio
  import irq_pkg::*;
#(
  parameter int unsigned NIRQ  = 15,
  parameter int unsigned VBITS = 4
) (
  input  logic [NIRQ-1:0]  req_i,
  output logic [VBITS-1:0] vec_o
);

  always_comb begin
    vec_o = VBITS'(IRQ_NONE);
    // Later iterations override earlier ones, so the highest index wins.
    for (int i = 0; i < NIRQ; i++) begin
      if (req_i[i]) begin
        vec_o = VBITS'(i + 1);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller: NIRQ maskable channels with edge/level
// capture, software set, write-1-to-clear and a registered priority vector.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NIRQ  = 15,
  parameter int unsigned VBITS = 4,
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             p_reset_n,
  input  logic [NIRQ-1:0]  src,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [1:0]       io_addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] io_dout,
  output logic             irq,
  output logic [VBITS-1:0] ivec,
  input  logic             iack
);

  logic [NIRQ-1:0]  pend_q, pend_d;
  logic [NIRQ-1:0]  enab_q, enab_d;
  logic [NIRQ-1:0]  mode_q, mode_d;
  logic [NIRQ-1:0]  src_prev_q, src_prev_d;
  logic [VBITS-1:0] ivec_q, ivec_d;

  logic [NIRQ-1:0]  hw_set, sw_set, w1c_clr, ack_clr;
  logic [NIRQ-1:0]  prio_req;
  logic [VBITS-1:0] prio_vec;
  logic [NIRQ-1:0]  wdata;

  // io_rd has no side effects and upper din bits are unmapped.
  logic unused_io;
  assign unused_io = ^{io_rd, din};

  assign wdata = din[NIRQ-1:0];

  always_comb begin
    hw_set  = (mode_q & src) | (~mode_q & src & ~src_prev_q);
    sw_set  = (io_wr && io_addr == IRQ_SWSET) ? wdata : '0;
    w1c_clr = (io_wr && io_addr == IRQ_PEND)  ? wdata : '0;
    for (int i = 0; i < NIRQ; i++) begin
      ack_clr[i] = iack && (ivec_q == VBITS'(i + 1));
    end
  end

  always_comb begin
    pend_d     = (pend_q & ~(w1c_clr | ack_clr)) | hw_set | sw_set;
    enab_d     = (io_wr && io_addr == IRQ_ENAB) ? wdata : enab_q;
    mode_d     = (io_wr && io_addr == IRQ_MODE) ? wdata : mode_q;
    src_prev_d = src;
  end

  // Only bits pending now and still pending next cycle compete: a cleared or
  // acked vector cannot reappear, while new events keep their two-cycle latency.
  assign prio_req = pend_d & pend_q & enab_q;

  irq_prio #(
    .NIRQ  (NIRQ),
    .VBITS (VBITS)
  ) u_prio (
    .req_i (prio_req),
    .vec_o (prio_vec)
  );

  assign ivec_d = prio_vec;

  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      pend_q     <= '0;
      enab_q     <= '0;
      mode_q     <= '0;
      src_prev_q <= '0;
      ivec_q     <= VBITS'(IRQ_NONE);
    end else begin
      pend_q     <= pend_d;
      enab_q     <= enab_d;
      mode_q     <= mode_d;
      src_prev_q <= src_prev_d;
      ivec_q     <= ivec_d;
    end
  end

  assign ivec = ivec_q;
  assign irq  = (ivec_q != VBITS'(IRQ_NONE));

  always_comb begin
    io_dout = '0;
    unique case (io_addr)
      IRQ_PEND:  io_dout = WIDTH'(pend_q);
      IRQ_ENAB:  io_dout = WIDTH'(enab_q);
      IRQ_MODE:  io_dout = WIDTH'(mode_q);
      IRQ_SWSET: io_dout = '0;
      default:   io_dout = '0;
    endcase
  end

endmodule
